// File: rtl/game_pkg.sv
// Shared colour constants and pixel types for the Flappy-Bird VGA pipeline.
package game_pkg;

  localparam logic [23:0] COLOR_BIRD  = 24'hFF0000;
  localparam logic [23:0] COLOR_PIPE  = 24'h00FF00;
  localparam logic [23:0] COLOR_SKY   = 24'h4EC0CA;
  localparam logic [23:0] COLOR_BLACK = 24'h000000;

  typedef struct packed {
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
  } rgb_t;

  // Object-flag pair as {bird, pipe}
  typedef enum logic [1:0] {
    PIX_SKY  = 2'b00,
    PIX_PIPE = 2'b01,
    PIX_BIRD = 2'b10,
    PIX_BOTH = 2'b11
  } pix_kind_t;

endpackage

// File: rtl/draw_game_if.sv
// Object-flag select into the colour mux and the resulting pixel colour.
interface draw_game_if;
  import game_pkg::*;

  logic [1:0] sel;
  rgb_t       rgb;

  modport master (output sel, input rgb);
  modport slave  (input sel, output rgb);
endinterface

// File: rtl/draw_game_color_sel.sv
// Combinational {bird, pipe} -> colour mux; an overlap falls back to sky.
module draw_game_color_sel
  import game_pkg::*;
#(
  parameter logic [23:0] BIRD_RGB = COLOR_BIRD,
  parameter logic [23:0] PIPE_RGB = COLOR_PIPE,
  parameter logic [23:0] SKY_RGB  = COLOR_SKY
) (
  draw_game_if.slave bus
);

  always_comb begin
    bus.rgb = rgb_t'(SKY_RGB);
    case (pix_kind_t'(bus.sel))
      PIX_PIPE: bus.rgb = rgb_t'(PIPE_RGB);
      PIX_BIRD: bus.rgb = rgb_t'(BIRD_RGB);
      default:  bus.rgb = rgb_t'(SKY_RGB);
    endcase
  end

endmodule

// File: rtl/draw_game.sv
// Pixel colour stage: registers the selected colour and a bird/pipe collision flag.
// One clock of latency; all outputs reset asynchronously to RESET_RGB / no collision.
module draw_game
  import game_pkg::*;
#(
  parameter logic [23:0] BIRD_RGB  = COLOR_BIRD,
  parameter logic [23:0] PIPE_RGB  = COLOR_PIPE,
  parameter logic [23:0] SKY_RGB   = COLOR_SKY,
  parameter logic [23:0] RESET_RGB = COLOR_BLACK
) (
  input  logic       clk,
  input  logic       bird_color,
  input  logic       pipe_color,
  output logic [7:0] red,
  output logic [7:0] green,
  output logic [7:0] blue,
  input  logic       rst,
  output logic       collision
);

  draw_game_if sel_bus ();

  assign sel_bus.sel = {bird_color, pipe_color};

  draw_game_color_sel #(
    .BIRD_RGB (BIRD_RGB),
    .PIPE_RGB (PIPE_RGB),
    .SKY_RGB  (SKY_RGB)
  ) u_color_sel (
    .bus (sel_bus.slave)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {red, green, blue} <= RESET_RGB;
      collision          <= 1'b0;
    end else begin
      {red, green, blue} <= sel_bus.rgb;
      collision          <= bird_color & pipe_color;
    end
  end

endmodule

// File: tb/tb_draw_game.sv
// Randomized bench for draw_game against a rule-level colour model.
module tb_draw_game;

  logic       clk;
  logic       rst;
  logic [7:0] red, green, blue;
  logic       collision;
  int         checks;
  int         errors;

  draw_game_if bus ();

  draw_game dut (
    .clk        (clk),
    .bird_color (bus.sel[1]),
    .pipe_color (bus.sel[0]),
    .red        (red),
    .green      (green),
    .blue       (blue),
    .rst        (rst),
    .collision  (collision)
  );

  initial clk = 1'b1;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected colour from the object rules: a lone object shows its colour, otherwise sky.
  function automatic logic [24:0] model(input logic bird, input logic pipe);
    logic [23:0] c;
    if (bird && !pipe)      c = 24'hFF0000;
    else if (pipe && !bird) c = 24'h00FF00;
    else                    c = 24'h4EC0CA;
    return {c, bird && pipe};
  endfunction

  function automatic logic [24:0] observed();
    return {red, green, blue, collision};
  endfunction

  logic [24:0] prev_exp;
  logic [24:0] new_exp;
  logic [1:0]  pat;
  logic [1:0]  table_pat [3];

  initial begin
    checks = 0;
    errors = 0;
    table_pat[0] = 2'b10;
    table_pat[1] = 2'b11;
    table_pat[2] = 2'b00;

    rst     = 1'b1;
    bus.sel = 2'bxx;
    for (int i = 0; i < 5; i++) begin
      #5 check("reset_hold", 32'(observed()), 32'h0);
      #5;
    end

    // t=50: release reset between edges, pipe only
    rst      = 1'b0;
    bus.sel  = 2'b01;
    prev_exp = 25'h0;
    #5 check("post_reset_wait", 32'(observed()), 32'(prev_exp));
    @(posedge clk); #1;
    prev_exp = model(1'b0, 1'b1);
    check("first_pipe", 32'(observed()), 32'(prev_exp));

    for (int i = 0; i < 203; i++) begin
      pat = (i < 3) ? table_pat[i] : 2'($urandom_range(0, 3));
      bus.sel = pat;
      new_exp = model(pat[1], pat[0]);
      #8 check("latency_hold", 32'(observed()), 32'(prev_exp));
      @(posedge clk); #1;
      check($sformatf("pix_b%0d_p%0d", pat[1], pat[0]), 32'(observed()), 32'(new_exp));
      prev_exp = new_exp;
    end

    // Mid-frame reset while the bird is showing
    bus.sel = 2'b10;
    @(posedge clk); #1;
    check("bird_before_rst", 32'(observed()), 32'(model(1'b1, 1'b0)));
    #4 rst = 1'b1;
    #1 check("async_rst", 32'(observed()), 32'h0);
    @(posedge clk); #1;
    check("rst_across_edge", 32'(observed()), 32'h0);
    #4 rst = 1'b0;
    #1 check("rst_release_hold", 32'(observed()), 32'h0);
    @(posedge clk); #1;
    check("bird_after_rst", 32'(observed()), 32'(model(1'b1, 1'b0)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
